cpu_record_extractor: RTL
=========================

// Module: cpu_record_extractor
// PURPOSE
//  Downstream companion of the CPU-trace format checker. Watches the same 8-bit char stream
//  and the checker's format_type verdict. Converts each accepted line into a binary record:
//   ^time@pc: $grf <= data#   or   ^time@pc: *addr <= data#
//  Buffers records in a small FIFO behind a valid/ready handshake for the next stage
//  (scoreboard / comparator).
// PARAMETERS
//  DEPTH     2    record FIFO entries; power of 2, >=2
//  DROP_W    8    width of saturating dropped-record counter
// PORTS
//  clk          in   1   single clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  char         in   8   ASCII char, one per cycle (same stream the checker samples)
//  format_type  in   2   checker output: 0 none, 1 grf line, 2 mem line; nonzero in the cycle after '#' is sampled
//  rec_valid    out  1   FIFO head holds a record
//  rec_ready    in   1   consumer accepts head on posedge when rec_valid&&rec_ready
//  rec_type     out  2   1 grf, 2 mem (copy of format_type at commit)
//  rec_time     out  14  decimal time field, binary
//  rec_pc       out  32  hex pc field
//  rec_dst      out  32  grf number (decimal, zero-extended 14b) or mem addr (hex)
//  rec_data     out  32  hex data field
//  drop_cnt     out  DROP_W  records lost to a full FIFO; saturates at all-ones
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, all accumulators 0, FIFO empty, rec_valid=0,
//    all rec_* = 0, drop_cnt=0. Reset mid-line discards the partial line.
//  - Field FSM, one transition per posedge on char; any char not listed -> IDLE:
//    '^' from ANY state -> TIME; clear time/pc/dst/data accumulators.
//    TIME: '0'-'9' t=t*10+d (mod 2^14); '@' -> PC.
//    PC: hex pc={pc[27:0],nib}; ':' -> SEL.
//    SEL: ' ' stay; '$' -> DST with kind=grf; '*' -> DST with kind=mem.
//    DST: grf decimal, same rule as TIME; mem hex; ' ' stay; '<' -> ARROW.
//    ARROW: '=' -> DATA, ' ' tolerated in DATA before the first digit.
//    DATA: hex shift into data; '#' -> DONE.
//    DONE: next char per table ('^' restarts, else IDLE).
//  - Hex digits: '0'-'9' and 'a'-'f' only. Upper case is not a digit.
//    More than 8 hex digits keeps the low 32 bits.
//  - Extractor does not validate format; the checker is the authority.
//  - Commit: in a cycle with state==DONE && format_type!=0, the posedge pushes
//    {format_type,time,pc,dst,data}. The FSM consumes the current char on the same edge;
//    the push uses the pre-edge accumulator values.
//  - format_type!=0 with state!=DONE: no push. state==DONE with format_type==0: no push.
//  - Push accepted if count<DEPTH, or if a pop occurs on the same edge.
//    Otherwise the record is dropped and drop_cnt increments, saturating.
//  - Latency: '#' sampled at edge N; record visible on rec_* after edge N+1 (if FIFO was empty).
//  - rec_* are FIFO head, registered. They are stable while rec_valid && !rec_ready.
//    They hold the last value when empty.
//  - Simultaneous push+pop on an empty FIFO is impossible (pop needs valid).
//    On a full FIFO, pop then push: count unchanged, no drop.
//  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
// STRUCTURE
//  - cpu_trace_defs.vh (shared): ASCII constants ^ @ : $ * < = # space; field widths
//    TIME_W=14, WORD_W=32; FSM state encodings; type codes 1/2.
//  - Sub-module cpu_record_fifo: DEPTH x 112-bit sync FIFO, async active-low reset,
//    push/pop/full/empty/count.
//  - Top holds the field FSM, accumulators, commit logic and drop counter.
// TESTING
//  1 "^10@00003000: $ 5 <= 0000abcd#", rec_ready=1
//    -> one record: type1 time10 pc0x3000 dst5 data0xabcd, rec_valid 1 cycle, drop_cnt 0.
//  2 "^1234@0000300c: *00000010 <= ffffffff#"
//    -> type2 time1234 pc0x300c dst0x10 data0xffffffff.
//  3 DEPTH=2, rec_ready=0, three valid lines
//    -> first two held in order, drop_cnt=1. rec_ready=1 -> both pop, then rec_valid=0.
//  4 "^10@00003000: $5 <= 1#" forced format_type=0 -> no record;
//    "^12^7@..." restart -> record time=7.
//  5 reset_n low mid-DATA, release, full line
//    -> rec_valid 0 during reset, only post-reset line emitted, fields unpolluted.
//  6 Full FIFO, rec_ready=1 on the commit cycle -> push accepted, drop_cnt unchanged.

Source files
------------

// File: rtl/cpu_record_extractor_pkg.sv
// Shared definitions for the CPU-trace record extractor: ASCII tokens,
// field widths, record type codes, field FSM states and char helpers.
package cpu_record_extractor_pkg;

  localparam int TIME_W = 14;
  localparam int WORD_W = 32;

  localparam logic [7:0] CH_CARET  = 8'h5e;  // '^'
  localparam logic [7:0] CH_AT     = 8'h40;  // '@'
  localparam logic [7:0] CH_COLON  = 8'h3a;  // ':'
  localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$'
  localparam logic [7:0] CH_STAR   = 8'h2a;  // '*'
  localparam logic [7:0] CH_LT     = 8'h3c;  // '<'
  localparam logic [7:0] CH_EQ     = 8'h3d;  // '='
  localparam logic [7:0] CH_HASH   = 8'h23;  // '#'
  localparam logic [7:0] CH_SPACE  = 8'h20;  // ' '

  localparam logic [1:0] TYPE_NONE = 2'd0;
  localparam logic [1:0] TYPE_GRF  = 2'd1;
  localparam logic [1:0] TYPE_MEM  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TIME  = 3'd1,
    ST_PC    = 3'd2,
    ST_SEL   = 3'd3,
    ST_DST   = 3'd4,
    ST_ARROW = 3'd5,
    ST_DATA  = 3'd6,
    ST_DONE  = 3'd7
  } fsm_state_e;

  // One committed line; field order matches {type,time,pc,dst,data}.
  typedef struct packed {
    logic [1:0]        rtype;
    logic [TIME_W-1:0] rtime;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] dst;
    logic [WORD_W-1:0] data;
  } record_t;

  localparam int REC_W = $bits(record_t);

  function automatic logic is_dec(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Lower-case hex only; 'A'-'F' are not digits.
  function automatic logic is_hex(input logic [7:0] c);
    return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return is_dec(c) ? c[3:0] : (c[3:0] + 4'd9);
  endfunction

  // acc*10 + digit, truncated to TIME_W bits.
  function automatic logic [TIME_W-1:0] dec_acc(input logic [TIME_W-1:0] acc,
                                                input logic [7:0]        c);
    return (acc << 3) + (acc << 1) + {{(TIME_W-4){1'b0}}, c[3:0]};
  endfunction

endpackage

// File: rtl/cpu_record_fifo.sv
// Small synchronous record FIFO. The head entry is kept in its own register
// so the outputs are registered and hold the last popped record when empty.
module cpu_record_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 112
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] head_q;
  logic             do_pop;
  logic             do_push;

  // Pop needs data; push is refused only when full and nothing leaves.
  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
  end

  // Storage, pointers, occupancy and the registered head entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (do_pop) begin
        if (count_q > CNT_W'(1)) head_q <= mem_q[rd_ptr_q + PTR_W'(1)];
        else if (do_push)        head_q <= push_data_i;
      end else if (do_push && (count_q == '0)) begin
        head_q <= push_data_i;
      end
    end
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/cpu_record_extractor.sv
// Parses the CPU-trace char stream into binary records and queues the lines
// the format checker accepts. Handshake: the head record transfers on a
// rising edge where rec_valid_o && rec_ready_i; rec_* stay stable while
// rec_valid_o is high and rec_ready_i is low.
module cpu_record_extractor
  import cpu_record_extractor_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DROP_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              char_i,
  input  logic [1:0]              format_type_i,
  input  logic                    rec_ready_i,
  output logic                    rec_valid_o,
  output logic [1:0]              rec_type_o,
  output logic [TIME_W-1:0]       rec_time_o,
  output logic [WORD_W-1:0]       rec_pc_o,
  output logic [WORD_W-1:0]       rec_dst_o,
  output logic [WORD_W-1:0]       rec_data_o,
  output logic [DROP_W-1:0]       drop_cnt_o,
  output fsm_state_e              state_o,
  output logic [$clog2(DEPTH):0]  fifo_count_o
);

  fsm_state_e        state_q;
  logic              kind_mem_q;
  logic              data_seen_q;
  logic [TIME_W-1:0] time_q;
  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] dst_q;
  logic [WORD_W-1:0] data_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic [DROP_W-1:0] drop_cnt_d;

  logic              commit;
  logic              pop;
  logic              push_ok;
  logic              fifo_full;
  logic              fifo_empty;
  record_t           push_rec;
  record_t           head_rec;

  // Field FSM: '^' restarts from anywhere, any unexpected char falls to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      kind_mem_q  <= 1'b0;
      data_seen_q <= 1'b0;
      time_q      <= '0;
      pc_q        <= '0;
      dst_q       <= '0;
      data_q      <= '0;
    end else if (char_i == CH_CARET) begin
      state_q     <= ST_TIME;
      kind_mem_q  <= 1'b0;
      data_seen_q <= 1'b0;
      time_q      <= '0;
      pc_q        <= '0;
      dst_q       <= '0;
      data_q      <= '0;
    end else begin
      case (state_q)
        ST_TIME: begin
          if (is_dec(char_i))       time_q  <= dec_acc(time_q, char_i);
          else if (char_i == CH_AT) state_q <= ST_PC;
          else                      state_q <= ST_IDLE;
        end
        ST_PC: begin
          if (is_hex(char_i))          pc_q    <= {pc_q[WORD_W-5:0], hex_val(char_i)};
          else if (char_i == CH_COLON) state_q <= ST_PC == ST_PC ? ST_SEL : ST_IDLE;
          else                         state_q <= ST_IDLE;
        end
        ST_SEL: begin
          if (char_i == CH_SPACE) begin
            state_q <= ST_SEL;
          end else if (char_i == CH_DOLLAR) begin
            state_q    <= ST_DST;
            kind_mem_q <= 1'b0;
          end else if (char_i == CH_STAR) begin
            state_q    <= ST_DST;
            kind_mem_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DST: begin
          if (kind_mem_q && is_hex(char_i))
            dst_q <= {dst_q[WORD_W-5:0], hex_val(char_i)};
          else if (!kind_mem_q && is_dec(char_i))
            dst_q <= {{(WORD_W-TIME_W){1'b0}}, dec_acc(dst_q[TIME_W-1:0], char_i)};
          else if (char_i == CH_LT)
            state_q <= ST_ARROW;
          else if (char_i != CH_SPACE)
            state_q <= ST_IDLE;
        end
        ST_ARROW: begin
          state_q <= (char_i == CH_EQ) ? ST_DATA : ST_IDLE;
        end
        ST_DATA: begin
          if (is_hex(char_i)) begin
            data_q      <= {data_q[WORD_W-5:0], hex_val(char_i)};
            data_seen_q <= 1'b1;
          end else if (char_i == CH_HASH) begin
            state_q <= ST_DONE;
          end else if (!(char_i == CH_SPACE && !data_seen_q)) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Commit uses the pre-edge accumulators; a pop frees room on the same edge.
  always_comb begin
    commit         = (state_q == ST_DONE) && (format_type_i != TYPE_NONE);
    pop            = rec_valid_o && rec_ready_i;
    push_ok        = commit && (!fifo_full || pop);
    push_rec.rtype = format_type_i;
    push_rec.rtime = time_q;
    push_rec.pc    = pc_q;
    push_rec.dst   = dst_q;
    push_rec.data  = data_q;
    drop_cnt_d     = drop_cnt_q;
    if (commit && !push_ok && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
  end

  // Saturating count of records lost to a full FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  cpu_record_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push_ok),
    .push_data_i (push_rec),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count_o),
    .head_o      (head_rec)
  );

  assign rec_valid_o = !fifo_empty;
  assign rec_type_o  = head_rec.rtype;
  assign rec_time_o  = head_rec.rtime;
  assign rec_pc_o    = head_rec.pc;
  assign rec_dst_o   = head_rec.dst;
  assign rec_data_o  = head_rec.data;
  assign drop_cnt_o  = drop_cnt_q;
  assign state_o     = state_q;

endmodule
